// File: rtl/scff_chain_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scff_chain_test_ctrl
// Description : On-chip sequencer for the fabric scan chain (sc_head ->
//               sc_tail). A start pulse raises test_en and flushes the chain
//               with CHAIN_LEN zeros. It then injects a single '1' and checks
//               that the pulse appears at sc_tail after exactly CHAIN_LEN
//               shifts, followed by PAD trailing zeros.
//
// Parameters  : CHAIN_LEN  scan flip-flops between sc_head and sc_tail (>=2)
//               PAD        trailing samples that must read '0' (>=1)
//               CNT_W      cycle-counter width, holds 2*CHAIN_LEN+PAD+1
//
// Ports       : clk        in   operating clock, also clocks the scan chain
//               greset     in   asynchronous active-high reset
//               start      in   starts a test when idle or done
//               abort      in   returns to IDLE from any state, beats start
//               test_en    out  scan-mode enable to the fabric
//               sc_head    out  scan chain serial input
//               sc_tail    in   scan chain serial output
//               busy       out  high while FLUSH/INJECT/SHIFT
//               done       out  high in DONE until the next start/abort
//               pass       out  valid with done, 1 iff no mismatch was seen
//               err_count  out  mismatches seen, saturating at 255
//               err_first  out  sample index of the first mismatch, 0 if none
//
// Revision    : 1.0  initial release
// ============================================================================
module scff_chain_test_ctrl #(
    parameter int CHAIN_LEN = 2304,
    parameter int PAD       = 2,
    parameter int CNT_W     = 13
) (
    input  logic             clk,
    input  logic             greset,
    input  logic             start,
    input  logic             abort,
    output logic             test_en,
    output logic             sc_head,
    input  logic             sc_tail,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] err_first
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FLUSH  = 3'd1;
    localparam logic [2:0] c_INJECT = 3'd2;
    localparam logic [2:0] c_SHIFT  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    // r_cnt holds the index n of the edge E_n about to occur (E0 = start edge).
    // Flushing ends on E_L; sample index k equals n - L for n in L+1..LAST.
    localparam logic [CNT_W-1:0] c_FLUSH_END = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_PULSE_K   = CNT_W'(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] c_LAST      = CNT_W'(2 * CHAIN_LEN + 1 + PAD);
    localparam logic [7:0]       c_ERR_MAX   = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_test_en;
    logic             r_sc_head;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_err_count;
    logic [CNT_W-1:0] r_err_first;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_test_en_nxt;
    logic             w_sc_head_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [7:0]       w_err_count_nxt;
    logic [CNT_W-1:0] w_err_first_nxt;

    // Compare path
    logic [CNT_W-1:0] w_k;
    logic             w_exp;
    logic             w_mismatch;
    logic [7:0]       w_err_count_upd;
    logic [CNT_W-1:0] w_err_first_upd;

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        w_state_nxt = c_FLUSH;
                    end
                end
                c_FLUSH: begin
                    if (r_cnt == c_FLUSH_END) begin
                        w_state_nxt = c_INJECT;
                    end
                end
                c_INJECT: begin
                    w_state_nxt = c_SHIFT;
                end
                c_SHIFT: begin
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = c_DONE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sample comparison. The first sample (k=1) is taken on the INJECT->SHIFT
    // edge; it sees the last flushed zero leaving the chain.
    // ------------------------------------------------------------------------
    assign w_k   = r_cnt - c_FLUSH_END;
    assign w_exp = (w_k == c_PULSE_K);

    always_comb begin
        // Written so that an unknown sc_tail falls through as a mismatch.
        w_mismatch = 1'b1;
        if (sc_tail == w_exp) begin
            w_mismatch = 1'b0;
        end
    end

    always_comb begin
        w_err_count_upd = r_err_count;
        w_err_first_upd = r_err_first;
        if (w_mismatch) begin
            if (r_err_count != c_ERR_MAX) begin
                w_err_count_upd = r_err_count + 8'd1;
            end
            if (r_err_count == 8'd0) begin
                w_err_first_upd = w_k;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: output / datapath next values (all outputs are registered)
    // ------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_test_en_nxt   = r_test_en;
        w_sc_head_nxt   = r_sc_head;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_err_count_nxt = r_err_count;
        w_err_first_nxt = r_err_first;

        if (abort) begin
            // Results survive an abort so the cause can still be read out.
            w_cnt_nxt     = '0;
            w_test_en_nxt = 1'b0;
            w_sc_head_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_pass_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        w_cnt_nxt       = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_test_en_nxt   = 1'b1;
                        w_sc_head_nxt   = 1'b0;
                        w_busy_nxt      = 1'b1;
                        w_done_nxt      = 1'b0;
                        w_pass_nxt      = 1'b0;
                        w_err_count_nxt = 8'd0;
                        w_err_first_nxt = '0;
                    end
                end
                c_FLUSH: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    // The '1' is registered on the last flush edge so the
                    // chain captures it on the following edge.
                    if (r_cnt == c_FLUSH_END) begin
                        w_sc_head_nxt = 1'b1;
                    end
                end
                c_INJECT: begin
                    w_cnt_nxt       = r_cnt + 1'b1;
                    w_sc_head_nxt   = 1'b0;
                    w_err_count_nxt = w_err_count_upd;
                    w_err_first_nxt = w_err_first_upd;
                end
                c_SHIFT: begin
                    w_err_count_nxt = w_err_count_upd;
                    w_err_first_nxt = w_err_first_upd;
                    if (r_cnt == c_LAST) begin
                        // Counter is held here so it never needs a wider range.
                        w_test_en_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_pass_nxt    = (w_err_count_upd == 8'd0);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt     = '0;
                    w_test_en_nxt = 1'b0;
                    w_sc_head_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b0;
                    w_pass_nxt    = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output and counter registers. Asynchronous reset drops test_en at once.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_cnt       <= '0;
            r_test_en   <= 1'b0;
            r_sc_head   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 8'd0;
            r_err_first <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_test_en   <= w_test_en_nxt;
            r_sc_head   <= w_sc_head_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_first <= w_err_first_nxt;
        end
    end

    assign test_en   = r_test_en;
    assign sc_head   = r_sc_head;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_first = r_err_first;

endmodule

`default_nettype wire

// File: tb/tb_scff_chain_test_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_scff_chain_test_ctrl
// Description : Scoreboard bench for scff_chain_test_ctrl with CHAIN_LEN=8,
//               PAD=2 and a behavioural scan chain of selectable length and
//               stuck-at behaviour. Expected results are queued at each start;
//               a monitor pops and compares them whenever done rises.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scff_chain_test_ctrl;

    localparam int c_CHAIN_LEN = 8;
    localparam int c_PAD       = 2;
    localparam int c_CNT_W     = 13;

    logic              clk = 1'b0;
    logic              greset;
    logic              start;
    logic              abort;
    logic              test_en;
    logic              sc_head;
    logic              sc_tail;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_count;
    logic [c_CNT_W-1:0] err_first;

    always #5 clk = ~clk;

    scff_chain_test_ctrl #(
        .CHAIN_LEN (c_CHAIN_LEN),
        .PAD       (c_PAD),
        .CNT_W     (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .greset    (greset),
        .start     (start),
        .abort     (abort),
        .test_en   (test_en),
        .sc_head   (sc_head),
        .sc_tail   (sc_tail),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_first (err_first)
    );

    // ------------------------------------------------------------------------
    // Behavioural scan chain: shifts while test_en is high.
    // tail_mode 0 = real chain, 1 = stuck-at-0, 2 = stuck-at-1.
    // ------------------------------------------------------------------------
    logic [15:0] chain;
    logic        chain_load;
    logic [15:0] chain_load_val;
    int          chain_len;
    int          tail_mode;

    always @(posedge clk) begin
        if (chain_load) chain <= chain_load_val;
        else if (test_en) chain <= {chain[14:0], sc_head};
    end

    always_comb begin
        case (tail_mode)
            1:       sc_tail = 1'b0;
            2:       sc_tail = 1'b1;
            default: sc_tail = chain[chain_len-1];
        endcase
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic        pass_v;
        logic [7:0]  cnt;
        logic [12:0] first;
        int          e0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   run_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: counts test_en / sc_head high cycles per run and scores each
    // rising edge of done against the oldest queued expectation.
    initial begin : monitor
        logic prev_done;
        int   seen_run;
        int   ten_cnt;
        int   head_cnt;
        exp_t e;
        prev_done = 1'b0;
        seen_run  = 0;
        ten_cnt   = 0;
        head_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (run_id != seen_run) begin
                seen_run = run_id;
                ten_cnt  = 0;
                head_cnt = 0;
            end
            if (test_en === 1'b1) ten_cnt++;
            if (sc_head === 1'b1) head_cnt++;
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency",   cyc - e.e0, 32'd19);
                    check("pass",           {31'd0, pass}, {31'd0, e.pass_v});
                    check("err_count",      {24'd0, err_count}, {24'd0, e.cnt});
                    check("err_first",      {19'd0, err_first}, {19'd0, e.first});
                    check("test_en_cycles", ten_cnt, 32'd19);
                    check("sc_head_cycles", head_cnt, 32'd1);
                    check("idle_at_done",   {30'd0, busy, test_en}, 32'd0);
                end
            end
            prev_done = done;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic pulse_start(input bit push, input logic p, input logic [7:0] c,
                               input logic [12:0] f);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.pass_v = p;
            e.cnt    = c;
            e.first  = f;
            e.e0     = cyc + 1;
            exp_q.push_back(e);
        end
        run_id++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_full(input int len, input int mode, input logic p,
                            input logic [7:0] c, input logic [12:0] f, input string name);
        chain_len = len;
        tail_mode = mode;
        pulse_start(1'b1, p, c, f);
        wait_done(name);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin : stim
        greset         = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        chain_len      = 8;
        tail_mode      = 0;
        chain_load     = 1'b1;
        chain_load_val = 16'hA5A5;
        repeat (3) @(negedge clk);
        chain_load = 1'b0;

        check("rst_test_en",   {31'd0, test_en}, 32'd0);
        check("rst_sc_head",   {31'd0, sc_head}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);
        check("rst_pass",      {31'd0, pass}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_err_first", {19'd0, err_first}, 32'd0);
        greset = 1'b0;
        @(negedge clk);

        // Ideal chain, stuck-at faults, short and long chains
        run_full(8, 0, 1'b1, 8'd0,  13'd0, "ideal");
        run_full(8, 1, 1'b0, 8'd1,  13'd9, "stuck0");
        run_full(8, 2, 1'b0, 8'd10, 13'd1, "stuck1");
        run_full(7, 0, 1'b0, 8'd2,  13'd8, "short");
        run_full(9, 0, 1'b0, 8'd2,  13'd9, "long");

        // Asynchronous reset in the middle of SHIFT
        chain_len = 8;
        tail_mode = 0;
        pulse_start(1'b0, 1'b0, 8'd0, 13'd0);
        repeat (11) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 greset = 1'b1;
        #1;
        check("async_test_en", {31'd0, test_en}, 32'd0);
        check("async_sc_head", {31'd0, sc_head}, 32'd0);
        check("async_busy",    {31'd0, busy}, 32'd0);
        check("async_done",    {31'd0, done}, 32'd0);
        @(negedge clk);
        greset = 1'b0;
        @(negedge clk);
        run_full(8, 0, 1'b1, 8'd0, 13'd0, "after_reset");

        // Second start during FLUSH is ignored; latency counts from first E0
        chain_len = 8;
        tail_mode = 0;
        pulse_start(1'b1, 1'b1, 8'd0, 13'd0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("flush_start");

        // Abort sampled at edge E5
        pulse_start(1'b0, 1'b0, 8'd0, 13'd0);
        repeat (4) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_test_en", {31'd0, test_en}, 32'd0);
        check("abort_busy",    {31'd0, busy}, 32'd0);
        check("abort_sc_head", {31'd0, sc_head}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {31'd0, test_en}, 32'd0);

        // start + abort together from DONE: abort wins, results retained
        run_full(8, 2, 1'b0, 8'd10, 13'd1, "stuck1_again");
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("sa_done",      {31'd0, done}, 32'd0);
        check("sa_pass",      {31'd0, pass}, 32'd0);
        check("sa_test_en",   {31'd0, test_en}, 32'd0);
        check("sa_err_count", {24'd0, err_count}, 32'd10);
        check("sa_err_first", {19'd0, err_first}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("sa_stays_idle", {30'd0, test_en, done}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
